// File: rtl/arima_anomaly_monitor.sv
// Multi-channel residual scoring, per-channel debounce and back-pressured onset event FIFO.
// Build option: define ANOMALY_DEBOUNCE_EN to enable min_run consecutive-hit debouncing.
module arima_anomaly_monitor #(
    parameter int N          = 32,
    parameter int Q          = 15,
    parameter int CH         = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int TS_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [5:0]        cfg_addr,
    input  logic [N-1:0]      cfg_wdata,
    input  logic              s_valid,
    input  logic [3:0]        s_ch,
    input  logic [N-1:0]      s_obs,
    input  logic [N-1:0]      s_pred,
    input  logic              s_init,
    output logic              out_valid,
    output logic [3:0]        out_ch,
    output logic              out_label,
    output logic [N-1:0]      out_score,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [3:0]        m_ch,
    output logic [TS_W-1:0]   m_ts,
    output logic [N-1:0]      m_score,
    output logic [15:0]       drop_cnt,
    output logic              overflow
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);

    localparam logic signed [N-1:0]   SAT_HI  = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0]   SAT_LO  = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [N+1:0]   R_MAX   = {3'b000, {(N-1){1'b1}}};
    localparam logic signed [2*N-1:0] P_HI    = {{(N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [2*N-1:0] P_LO    = {{(N+1){1'b1}}, {(N-1){1'b0}}};
    localparam logic signed [N-1:0]   INV_ONE = {{(N-1){1'b0}}, 1'b1} << Q;

    logic signed [N-1:0] mean_q    [CH];
    logic signed [N-1:0] inv_var_q [CH];
    logic signed [N-1:0] thr_q     [CH];
`ifdef ANOMALY_DEBOUNCE_EN
    logic [7:0]          min_run_q [CH];
    logic [7:0]          run_q     [CH];
`endif
    logic                label_q   [CH];
    logic [TS_W-1:0]     ts_q      [CH];

    logic [3:0]     cfg_ch;
    logic [1:0]     cfg_reg;
    logic           cfg_hit;
    logic [CHW-1:0] cfg_idx;

    assign cfg_ch  = cfg_addr[5:2];
    assign cfg_reg = cfg_addr[1:0];
    assign cfg_idx = cfg_ch[CHW-1:0];
    assign cfg_hit = cfg_we && ({1'b0, cfg_ch} < 5'(CH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                mean_q[i]    <= '0;
                inv_var_q[i] <= INV_ONE;
                thr_q[i]     <= SAT_HI;
`ifdef ANOMALY_DEBOUNCE_EN
                min_run_q[i] <= 8'd1;
`endif
            end
        end else if (cfg_hit) begin
            case (cfg_reg)
                2'd0: mean_q[cfg_idx]    <= cfg_wdata;
                2'd1: inv_var_q[cfg_idx] <= cfg_wdata;
                2'd2: thr_q[cfg_idx]     <= cfg_wdata;
`ifdef ANOMALY_DEBOUNCE_EN
                2'd3: min_run_q[cfg_idx] <= (cfg_wdata[7:0] == 8'd0) ? 8'd1 : cfg_wdata[7:0];
`endif
                default: ;
            endcase
        end
    end

    // Stage 1: residual magnitude, plus a snapshot of the channel's config
    logic           in_ok;
    logic [CHW-1:0] s_idx;
    logic signed [N+1:0] r_full, r_abs;
    logic           r_sat;

    assign in_ok  = s_valid && ({1'b0, s_ch} < 5'(CH));
    assign s_idx  = s_ch[CHW-1:0];
    assign r_full = {{2{s_obs[N-1]}}, s_obs} - {{2{s_pred[N-1]}}, s_pred}
                  - {{2{mean_q[s_idx][N-1]}}, mean_q[s_idx]};
    assign r_abs  = r_full[N+1] ? -r_full : r_full;
    assign r_sat  = r_abs > R_MAX;

    logic                s1_valid, s1_init, s1_ovf;
    logic [3:0]          s1_ch;
    logic [N-1:0]        s1_abs;
    logic signed [N-1:0] s1_inv, s1_thr;
`ifdef ANOMALY_DEBOUNCE_EN
    logic [7:0]          s1_min_run;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_init    <= 1'b0;
            s1_ovf     <= 1'b0;
            s1_ch      <= '0;
            s1_abs     <= '0;
            s1_inv     <= '0;
            s1_thr     <= '0;
`ifdef ANOMALY_DEBOUNCE_EN
            s1_min_run <= '0;
`endif
        end else begin
            s1_valid <= in_ok;
            if (in_ok) begin
                s1_init    <= s_init;
                s1_ovf     <= r_sat;
                s1_ch      <= s_ch;
                s1_abs     <= r_sat ? SAT_HI : r_abs[N-1:0];
                s1_inv     <= inv_var_q[s_idx];
                s1_thr     <= thr_q[s_idx];
`ifdef ANOMALY_DEBOUNCE_EN
                s1_min_run <= min_run_q[s_idx];
`endif
            end
        end
    end

    // Stage 2 arithmetic: normalise, saturate, threshold
    logic signed [2*N-1:0] abs_ext, inv_ext, p, p_sh;
    logic signed [N-1:0]   score2;
    logic                  ovf2, hit2;

    assign abs_ext = {{N{1'b0}}, s1_abs};
    assign inv_ext = {{N{s1_inv[N-1]}}, s1_inv};
    assign p       = abs_ext * inv_ext;
    assign p_sh    = p >>> Q;

    always_comb begin
        score2 = p_sh[N-1:0];
        ovf2   = 1'b0;
        if (p_sh > P_HI) begin
            score2 = SAT_HI;
            ovf2   = 1'b1;
        end else if (p_sh < P_LO) begin
            score2 = SAT_LO;
            ovf2   = 1'b1;
        end
    end

    assign hit2 = score2 > s1_thr;

    logic                s2_valid, s2_init, s2_ovf, s2_hit;
    logic [3:0]          s2_ch;
    logic [N-1:0]        s2_score;
`ifdef ANOMALY_DEBOUNCE_EN
    logic [7:0]          s2_min_run;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid   <= 1'b0;
            s2_init    <= 1'b0;
            s2_ovf     <= 1'b0;
            s2_hit     <= 1'b0;
            s2_ch      <= '0;
            s2_score   <= '0;
`ifdef ANOMALY_DEBOUNCE_EN
            s2_min_run <= '0;
`endif
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_init    <= s1_init;
                s2_ovf     <= s1_ovf | ovf2;
                s2_hit     <= hit2;
                s2_ch      <= s1_ch;
                s2_score   <= score2;
`ifdef ANOMALY_DEBOUNCE_EN
                s2_min_run <= s1_min_run;
`endif
            end
        end
    end

    // Per-channel state is read and written only here, so same-channel samples never collide
    logic [CHW-1:0] f_idx;
    logic           lab_new, onset;
`ifdef ANOMALY_DEBOUNCE_EN
    logic [7:0]     run_new;
`endif

    assign f_idx = s2_ch[CHW-1:0];

    always_comb begin
        lab_new = 1'b0;
`ifdef ANOMALY_DEBOUNCE_EN
        run_new = 8'd0;
        if (!s2_init) begin
            if (s2_hit)
                run_new = (run_q[f_idx] == 8'hFF) ? 8'hFF : run_q[f_idx] + 8'd1;
            lab_new = run_new >= s2_min_run;
        end
`else
        lab_new = s2_hit && !s2_init;
`endif
    end

    assign onset = s2_valid && lab_new && !label_q[f_idx];

    logic [AW:0]   cnt, occ;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          pend, pop, accept;
    logic [3:0]    pend_ch;
    logic [TS_W-1:0] pend_ts;
    logic [N-1:0]  pend_score;

    // Occupancy counts the registered write still in flight so a drop is decided with the label
    assign occ    = cnt + (AW+1)'(pend);
    assign pop    = m_valid && m_ready;
    assign accept = onset && ((occ < (AW+1)'(FIFO_DEPTH)) || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                label_q[i] <= 1'b0;
                ts_q[i]    <= '0;
`ifdef ANOMALY_DEBOUNCE_EN
                run_q[i]   <= '0;
`endif
            end
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_label <= 1'b0;
            out_score <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                label_q[f_idx] <= lab_new;
                ts_q[f_idx]    <= ts_q[f_idx] + TS_W'(1);
`ifdef ANOMALY_DEBOUNCE_EN
                run_q[f_idx]   <= run_new;
`endif
                out_ch    <= s2_ch;
                out_label <= lab_new;
                out_score <= s2_score;
                overflow  <= overflow | s2_ovf;
            end
            if (onset && !accept && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    logic [3:0]      mem_ch    [FIFO_DEPTH];
    logic [TS_W-1:0] mem_ts    [FIFO_DEPTH];
    logic [N-1:0]    mem_score [FIFO_DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pend       <= 1'b0;
            pend_ch    <= '0;
            pend_ts    <= '0;
            pend_score <= '0;
        end else begin
            pend <= accept;
            if (accept) begin
                pend_ch    <= s2_ch;
                pend_ts    <= ts_q[f_idx];
                pend_score <= s2_score;
            end
            if (pend)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(pend) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (pend) begin
            mem_ch[wr_ptr]    <= pend_ch;
            mem_ts[wr_ptr]    <= pend_ts;
            mem_score[wr_ptr] <= pend_score;
        end
    end

    assign m_valid = (cnt != '0);
    assign m_ch    = m_valid ? mem_ch[rd_ptr]    : '0;
    assign m_ts    = m_valid ? mem_ts[rd_ptr]    : '0;
    assign m_score = m_valid ? mem_score[rd_ptr] : '0;

endmodule

// File: tb/tb_arima_anomaly_monitor.sv
// Scoreboard bench for arima_anomaly_monitor: arithmetic reference model plus an event-queue FIFO model.
module tb_arima_anomaly_monitor;
    localparam int N = 32, Q = 15, CH = 4, FD = 16, TS_W = 16;
    localparam longint MAXP = 64'sh7FFFFFFF;
    localparam longint MINN = -64'sh80000000;

    logic              clk = 1'b0, reset = 1'b1;
    logic              cfg_we = 1'b0;
    logic [5:0]        cfg_addr = '0;
    logic [N-1:0]      cfg_wdata = '0;
    logic              s_valid = 1'b0, s_init = 1'b0;
    logic [3:0]        s_ch = '0;
    logic [N-1:0]      s_obs = '0, s_pred = '0;
    logic              out_valid, out_label, m_valid, overflow;
    logic              m_ready = 1'b1;
    logic [3:0]        out_ch, m_ch;
    logic [N-1:0]      out_score, m_score;
    logic [TS_W-1:0]   m_ts;
    logic [15:0]       drop_cnt;

    arima_anomaly_monitor #(.N(N), .Q(Q), .CH(CH), .FIFO_DEPTH(FD), .TS_W(TS_W)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .s_valid(s_valid), .s_ch(s_ch), .s_obs(s_obs), .s_pred(s_pred), .s_init(s_init),
        .out_valid(out_valid), .out_ch(out_ch), .out_label(out_label), .out_score(out_score),
        .m_valid(m_valid), .m_ready(m_ready), .m_ch(m_ch), .m_ts(m_ts), .m_score(m_score),
        .drop_cnt(drop_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct { int ch; bit label; logic [31:0] score; bit onset; int ts; bit ovf; } out_t;
    typedef struct { int ch; int ts; logic [31:0] score; } ev_t;

    out_t exp_q[$];
    ev_t  ev_q[$];
    int   checks = 0, failures = 0;
    int   model_occ, exp_drop;

    longint m_mean[CH], m_inv[CH], m_thr[CH];
    int     m_minrun[CH], m_run[CH], m_ts_c[CH];
    bit     m_lab[CH];
    bit     m_ovf;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_mean[i] = 0; m_inv[i] = 1 << Q; m_thr[i] = MAXP;
            m_minrun[i] = 1; m_run[i] = 0; m_ts_c[i] = 0; m_lab[i] = 0;
        end
        m_ovf = 0; model_occ = 0; exp_drop = 0;
        exp_q.delete();
        ev_q.delete();
    endtask

    task automatic model_sample(input int ch, input logic [31:0] obs, input logic [31:0] pred, input bit init);
        longint r, a, p, sc;
        bit ov, hit, lab;
        out_t e;
        r = longint'($signed(obs)) - longint'($signed(pred)) - m_mean[ch];
        a = (r < 0) ? -r : r;
        ov = 0;
        if (a > MAXP) begin a = MAXP; ov = 1; end
        p = a * m_inv[ch];
        sc = p >>> Q;
        if (sc > MAXP) begin sc = MAXP; ov = 1; end
        if (sc < MINN) begin sc = MINN; ov = 1; end
        hit = sc > m_thr[ch];
        lab = 0;
        if (init) m_run[ch] = 0;
        else begin
`ifdef ANOMALY_DEBOUNCE_EN
            m_run[ch] = hit ? ((m_run[ch] < 255) ? m_run[ch] + 1 : 255) : 0;
            lab = m_run[ch] >= ((m_minrun[ch] == 0) ? 1 : m_minrun[ch]);
`else
            lab = hit;
`endif
        end
        m_ovf |= ov;
        e.ch = ch; e.label = lab; e.score = sc[31:0]; e.onset = lab && !m_lab[ch];
        e.ts = m_ts_c[ch]; e.ovf = m_ovf;
        m_lab[ch] = lab;
        m_ts_c[ch] = (m_ts_c[ch] + 1) % (1 << TS_W);
        exp_q.push_back(e);
    endtask

    task automatic model_cfg(input int ch, input int rg, input logic [31:0] d);
        if (ch < CH) begin
            case (rg)
                0: m_mean[ch] = longint'($signed(d));
                1: m_inv[ch]  = longint'($signed(d));
                2: m_thr[ch]  = longint'($signed(d));
                default: m_minrun[ch] = int'(d[7:0]);
            endcase
        end
    endtask

    task automatic drive(input bit v, input int ch, input logic [31:0] obs, input logic [31:0] pred,
                         input bit init, input bit we, input int cch, input int rg, input logic [31:0] d);
        s_valid = v; s_ch = ch[3:0]; s_obs = obs; s_pred = pred; s_init = init;
        cfg_we = we; cfg_addr = {cch[3:0], rg[1:0]}; cfg_wdata = d;
        if (v && ch < CH) model_sample(ch, obs, pred, init);
        if (we) model_cfg(cch, rg, d);
        @(posedge clk); #1;
        s_valid = 0; cfg_we = 0; s_init = 0;
    endtask

    task automatic samp(input int ch, input logic [31:0] obs, input logic [31:0] pred, input bit init);
        drive(1, ch, obs, pred, init, 0, 0, 0, 0);
    endtask

    task automatic cfg(input int ch, input int rg, input logic [31:0] d);
        drive(0, 0, 0, 0, 0, 1, ch, rg, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic bit any_out();
        return |{out_valid, out_ch, out_label, out_score, m_valid, m_ch, m_ts, m_score, drop_cnt, overflow};
    endfunction

    initial begin : monitor
        out_t e;
        ev_t  v;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL out_unexpected actual=1 required=0 ch=%0d at %0t", out_ch, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_ch", out_ch, e.ch);
                        check("out_label", out_label, e.label);
                        check("out_score", out_score, e.score);
                        check("overflow", overflow, e.ovf);
                        if (e.onset) begin
                            if (model_occ < FD) begin
                                v.ch = e.ch; v.ts = e.ts; v.score = e.score;
                                ev_q.push_back(v);
                                model_occ++;
                            end else if (exp_drop < 65535) exp_drop++;
                        end
                        check("drop_cnt", drop_cnt, exp_drop);
                    end
                end
                if (m_valid && m_ready) begin
                    if (ev_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL pop_unexpected actual=ch%0d/ts%0d required=none at %0t", m_ch, m_ts, $time);
                    end else begin
                        v = ev_q.pop_front();
                        check("m_ch", m_ch, v.ch);
                        check("m_ts", m_ts, v.ts);
                        check("m_score", m_score, v.score);
                        model_occ--;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        model_reset();
        #12;
        check("reset_outputs_zero", any_out(), 0);
        @(posedge clk); #1 reset = 0;
        idle(2);
        check("post_reset_idle_zero", any_out(), 0);

        // defaults with a lowered threshold
        cfg(0, 2, 32'h8000);
        samp(0, 32'h00010000, 0, 0);
        idle(4);

        // debounce on ch1
        cfg(1, 3, 3);
        cfg(1, 2, 32'h100);
        for (int i = 0; i < 4; i++) samp(1, 32'h1000, 0, 0);
        samp(1, 32'h10, 0, 0);
        idle(4);

        // interleaved channels with independent timestamps
        samp(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            samp(0, 32'h00010000, 0, 0);
            samp(1, 32'h10, 0, 0);
        end
        idle(10);

        // fill and overfill the event FIFO
        cfg(2, 2, 32'h100);
        m_ready = 0;
        for (int i = 0; i < 20; i++) begin
            samp(2, 32'h1000, 0, 0);
            samp(2, 0, 0, 0);
        end
        idle(5);
        check("fifo_drop_after_20", drop_cnt, 4);
        samp(2, 32'h1000, 0, 0);
        idle(1);
        m_ready = 1;
        @(posedge clk); #1;
        m_ready = 0;
        samp(2, 0, 0, 0);
        idle(4);
        check("fifo_push_pop_full", drop_cnt, 4);
        m_ready = 1;
        idle(25);

        // saturation is sticky
        cfg(3, 1, 32'h7FFFFFFF);
        samp(3, 32'h7FFFFFFF, 32'h80000000, 0);
        idle(4);
        check("overflow_set", overflow, 1);
        samp(3, 0, 0, 0);
        idle(4);
        check("overflow_sticky", overflow, 1);

        // randomized traffic with config writes and back-pressure
        for (int it = 0; it < 400; it++) begin
            bit v, we, ini;
            int ch, cch, rg;
            logic [31:0] obs, pred, d;
            m_ready = ($urandom_range(0, 3) != 0);
            v   = ($urandom_range(0, 3) != 0);
            ch  = $urandom_range(0, 5);
            obs = $urandom;
            pred = obs + $urandom_range(0, 32'h3000) - 32'h1800;
            ini = ($urandom_range(0, 15) == 0);
            we  = ($urandom_range(0, 7) == 0);
            cch = $urandom_range(0, 5);
            rg  = $urandom_range(0, 3);
            case (rg)
                0: d = $urandom_range(0, 32'h2000) - 32'h1000;
                1: d = $urandom_range(0, 32'h20000);
                2: d = $urandom_range(0, 32'h3000);
                default: d = $urandom_range(0, 4);
            endcase
            drive(v, ch, obs, pred, ini, we, cch, rg, d);
        end
        m_ready = 1;
        idle(30);

        // reset during a burst with the FIFO partly filled
        cfg(0, 0, 0); cfg(0, 1, 32'h8000); cfg(0, 2, 32'h100); cfg(0, 3, 1);
        m_ready = 0;
        samp(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            samp(0, 32'h1000, 0, 0);
            samp(0, 0, 0, 0);
        end
        samp(0, 32'h1000, 0, 0);
        samp(1, 32'h1000, 0, 0);
        #1 reset = 1;
        #1 check("reset_mid_zero", any_out(), 0);
        model_reset();
        @(posedge clk); #1 reset = 0;
        m_ready = 1;
        idle(1);
        cfg(0, 2, 32'h8000);
        samp(0, 32'h00010000, 0, 0);
        idle(6);

        // drain
        m_ready = 1;
        n = 0;
        while ((exp_q.size() != 0 || ev_q.size() != 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0 || ev_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout actual=out%0d/ev%0d required=0/0", exp_q.size(), ev_q.size());
        end
        idle(2);
        check("final_m_valid", m_valid, 0);
        check("final_drop_cnt", drop_cnt, exp_drop);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
